// File: rtl/mem_bus_arbiter_if.sv
// ============================================================================
// Module   : mem_bus_arbiter_if
// Brief    : Valid/ready memory bus bundle shared by masters, arbiter and slave.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_bus_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;

    modport master (
        output valid,
        output addr,
        output wdata,
        output wstrb,
        input  ready,
        input  rdata
    );

    modport slave (
        input  valid,
        input  addr,
        input  wdata,
        input  wstrb,
        output ready,
        output rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Two-master valid/ready bus arbiter with transfer watchdog.
//            MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of m0 priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mem_bus_arbiter_if.slave       i_m0,
    mem_bus_arbiter_if.slave       i_m1,
    mem_bus_arbiter_if.master      o_mem,
    output logic                   o_grant,
    output logic                   o_bus_err
);

    localparam int                    c_WDOG_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WDOG_W-1:0]   c_WDOG_LAST = c_WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_owner;
    logic                w_owner_nxt;
    logic                r_last_owner;
    logic                w_last_owner_nxt;
    logic [c_WDOG_W-1:0] r_wdog;
    logic [c_WDOG_W-1:0] w_wdog_nxt;
    logic                r_bus_err;
    logic                w_bus_err_nxt;

    logic                w_winner;
    logic                w_own_valid;
    logic                w_timeout;
    logic                w_done;
    logic [31:0]         w_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Contention alternates away from the previous owner; a lone requester wins.
    assign w_winner = (i_m0.valid && i_m1.valid) ? ~r_last_owner : i_m1.valid;
`else
    assign w_winner = ~i_m0.valid;
`endif

    assign w_own_valid = r_owner ? i_m1.valid : i_m0.valid;
    assign w_timeout   = (r_wdog == c_WDOG_LAST);
    assign w_done      = (r_state == S_BUSY) && w_own_valid && (o_mem.ready || w_timeout);
    assign w_rdata     = o_mem.ready ? o_mem.rdata : ERR_RDATA;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_wdog       <= '0;
            r_bus_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_wdog       <= w_wdog_nxt;
            r_bus_err    <= w_bus_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_wdog_nxt       = r_wdog;
        w_bus_err_nxt    = r_bus_err;
        case (r_state)
            S_IDLE: begin
                if (i_m0.valid || i_m1.valid) begin
                    w_owner_nxt = w_winner;
                    w_wdog_nxt  = '0;
                    w_state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                // An abandoned request ends silently; the slave answer wins a tie with the watchdog.
                if (!w_own_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (o_mem.ready) begin
                    w_last_owner_nxt = r_owner;
                    w_state_nxt      = S_IDLE;
                end else if (w_timeout) begin
                    w_last_owner_nxt = r_owner;
                    w_bus_err_nxt    = 1'b1;
                    w_state_nxt      = S_IDLE;
                end else begin
                    w_wdog_nxt = r_wdog + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_mem.valid = (r_state == S_BUSY) && w_own_valid;
    assign o_mem.addr  = (r_state != S_BUSY) ? 32'h0 : (r_owner ? i_m1.addr  : i_m0.addr);
    assign o_mem.wdata = (r_state != S_BUSY) ? 32'h0 : (r_owner ? i_m1.wdata : i_m0.wdata);
    assign o_mem.wstrb = (r_state != S_BUSY) ? 4'h0  : (r_owner ? i_m1.wstrb : i_m0.wstrb);

    assign i_m0.ready = w_done && !r_owner;
    assign i_m0.rdata = (w_done && !r_owner) ? w_rdata : 32'h0;
    assign i_m1.ready = w_done && r_owner;
    assign i_m1.rdata = (w_done && r_owner) ? w_rdata : 32'h0;

    assign o_grant   = r_owner;
    assign o_bus_err = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Directed vector bench for mem_bus_arbiter (watchdog shortened to 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int c_T = 8;

    logic clk = 1'b0;
    logic rst;
    logic grant;
    logic bus_err;

    always #5 clk = ~clk;

    mem_bus_arbiter_if m0_if ();
    mem_bus_arbiter_if m1_if ();
    mem_bus_arbiter_if mem_if ();

    mem_bus_arbiter #(
        .TIMEOUT_CYCLES (c_T),
        .ERR_RDATA      (32'hDEADBEEF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_m0      (m0_if),
        .i_m1      (m1_if),
        .o_mem     (mem_if),
        .o_grant   (grant),
        .o_bus_err (bus_err)
    );

    typedef struct {
        int          m;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] slv_rdata;
        logic [31:0] exp_rdata;
        int          exp_cyc;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_m(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s);
        if (m == 0) begin
            m0_if.valid = v; m0_if.addr = a; m0_if.wdata = w; m0_if.wstrb = s;
        end else begin
            m1_if.valid = v; m1_if.addr = a; m1_if.wdata = w; m1_if.wstrb = s;
        end
    endtask

    function automatic logic rdy(input int m);
        return (m == 0) ? m0_if.ready : m1_if.ready;
    endfunction

    function automatic logic [31:0] rdat(input int m);
        return (m == 0) ? m0_if.rdata : m1_if.rdata;
    endfunction

    task automatic apply_reset();
        @(negedge clk); rst = 1'b1; #1;
        @(negedge clk); rst = 1'b0; #1;
    endtask

    // Single-master transaction with a slave that answers after v.lat stall cycles.
    task automatic run_txn(input vec_t v, input logic exp_err);
        bit done = 0;
        @(negedge clk);
        set_m(v.m, 1'b1, v.addr, v.wdata, v.wstrb);
        mem_if.ready = 1'b0;
        #1;
        chk("idle_mem_valid", 32'(mem_if.valid), 32'h0);
        chk("idle_mem_addr", mem_if.addr, 32'h0);
        chk("idle_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
        for (int c = 1; c <= c_T + 4 && !done; c++) begin
            @(negedge clk);
            mem_if.ready = ((c - 1) == v.lat);
            mem_if.rdata = v.slv_rdata;
            #1;
            if (c == 1) begin
                chk("busy_mem_valid", 32'(mem_if.valid), 32'h1);
                chk("busy_mem_addr", mem_if.addr, v.addr);
                chk("busy_mem_wdata", mem_if.wdata, v.wdata);
                chk("busy_mem_wstrb", 32'(mem_if.wstrb), 32'(v.wstrb));
                chk("busy_grant", 32'(grant), 32'(v.m));
            end
            if (rdy(v.m)) begin
                done = 1;
                chk("txn_latency", 32'(c), 32'(v.exp_cyc));
                chk("txn_rdata", rdat(v.m), v.exp_rdata);
                chk("nonowner_ready", 32'(rdy(1 - v.m)), 32'h0);
                chk("nonowner_rdata", rdat(1 - v.m), 32'h0);
            end
        end
        if (!done) chk("txn_no_ready", 32'h0, 32'h1);
        @(negedge clk);
        set_m(v.m, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        #1;
        chk("post_mem_valid", 32'(mem_if.valid), 32'h0);
        chk("post_grant", 32'(grant), 32'(v.m));
        chk("post_bus_err", 32'(bus_err), 32'(exp_err));
    endtask

    vec_t vecs [5];
    int   got [4];

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vecs[0] = '{0, 32'h00050000, 32'h0,        4'h0, 1,       32'h12345678, 32'h12345678, 2};
        vecs[1] = '{1, 32'h03000000, 32'h000000A5, 4'hF, 0,       32'h0,        32'h0,        1};
        vecs[2] = '{0, 32'h00001004, 32'hCAFEF00D, 4'h3, 3,       32'h0,        32'h0,        4};
        vecs[3] = '{1, 32'h00050010, 32'h0,        4'h0, 2,       32'h55AA00FF, 32'h55AA00FF, 3};
        vecs[4] = '{0, 32'h00050020, 32'h0,        4'h0, c_T - 1, 32'h0BADF00D, 32'h0BADF00D, c_T};

        rst = 1'b1;
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        mem_if.rdata = 32'h0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_mem_valid", 32'(mem_if.valid), 32'h0);
        chk("rst_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_bus_err", 32'(bus_err), 32'h0);
        @(negedge clk); rst = 1'b0; #1;

        // Single transactions, including mem_ready on the exact timeout cycle.
        for (int i = 0; i < 5; i++) run_txn(vecs[i], 1'b0);

        // Both masters requesting continuously, starting from reset state.
        apply_reset();
        @(negedge clk);
        set_m(0, 1'b1, 32'h00050100, 32'h0, 4'h0);
        set_m(1, 1'b1, 32'h00050200, 32'h0, 4'h0);
        mem_if.ready = 1'b1;
        mem_if.rdata = 32'h11111111;
        begin
            int  n    = 0;
            bit  prev = 0;
            for (int c = 0; c < 40 && n < 4; c++) begin
                @(negedge clk); #1;
                if (prev) chk("b2b_idle_gap", 32'(mem_if.valid), 32'h0);
                prev = m0_if.ready || m1_if.ready;
                if (m0_if.ready)      begin got[n] = 0; n++; end
                else if (m1_if.ready) begin got[n] = 1; n++; end
            end
            chk("contend_count", 32'(n), 32'h4);
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("contend_g0", 32'(got[0]), 32'h0);
        chk("contend_g1", 32'(got[1]), 32'h1);
        chk("contend_g2", 32'(got[2]), 32'h0);
        chk("contend_g3", 32'(got[3]), 32'h1);
`else
        chk("contend_g0", 32'(got[0]), 32'h0);
        chk("contend_g1", 32'(got[1]), 32'h0);
        chk("contend_g2", 32'(got[2]), 32'h0);
        chk("contend_g3", 32'(got[3]), 32'h0);
`endif
        @(negedge clk);
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        @(negedge clk); #1;

        // Owner abandons its request mid-transfer.
        set_m(1, 1'b1, 32'h00050300, 32'h0, 4'h0);
        @(negedge clk); #1;
        chk("drop_busy_valid", 32'(mem_if.valid), 32'h1);
        @(negedge clk);
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_if.ready = 1'b1;
        #1;
        chk("drop_mem_valid", 32'(mem_if.valid), 32'h0);
        chk("drop_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
        run_txn('{0, 32'h00050400, 32'h0, 4'h0, 0, 32'h00000042, 32'h00000042, 1}, 1'b0);

        // Unanswered address trips the watchdog.
        @(negedge clk);
        set_m(0, 1'b1, 32'h01000000, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        #1;
        begin
            bit done = 0;
            for (int c = 1; c <= c_T + 4 && !done; c++) begin
                @(negedge clk); #1;
                if (m0_if.ready) begin
                    done = 1;
                    chk("tmo_latency", 32'(c), 32'(c_T));
                    chk("tmo_rdata", m0_if.rdata, 32'hDEADBEEF);
                end
            end
            if (!done) chk("tmo_no_ready", 32'h0, 32'h1);
        end
        @(negedge clk);
        set_m(0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("tmo_mem_valid", 32'(mem_if.valid), 32'h0);
        chk("tmo_bus_err", 32'(bus_err), 32'h1);
        run_txn('{1, 32'h00050500, 32'h0, 4'h0, 1, 32'h00000077, 32'h00000077, 2}, 1'b1);

        // Reset while a stalled transfer is in flight.
        @(negedge clk);
        set_m(1, 1'b1, 32'h00050600, 32'h0, 4'h0);
        mem_if.ready = 1'b0;
        @(negedge clk); #1;
        chk("rstmid_grant_pre", 32'(grant), 32'h1);
        chk("rstmid_valid_pre", 32'(mem_if.valid), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_mem_valid", 32'(mem_if.valid), 32'h0);
        chk("rstmid_ready", 32'({m1_if.ready, m0_if.ready}), 32'h0);
        chk("rstmid_bus_err", 32'(bus_err), 32'h0);
        chk("rstmid_grant", 32'(grant), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        set_m(1, 1'b0, 32'h0, 32'h0, 4'h0);
        run_txn('{1, 32'h00050700, 32'h0, 4'h0, 0, 32'h000000C3, 32'h000000C3, 1}, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
